ifu_fetchq: RTL and testbench

Parametrised instruction-fetch unit with a decoupling fetch queue, successor to the single-register fetch stage. Issues pipelined, in-order fetches on a request/grant/response instruction bus, tracks up to DEPTH in-flight or buffered instructions, and presents them to idu through a valid/ready interface. Handles flush and jump redirects by squashing buffered entries and discarding responses still in flight.

---
 rtl/ifu_fetchq.sv | 181 ++++++++++++++++++
 tb/tb_ifu_fetchq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetchq.sv
// ifu_fetchq: instruction-fetch unit with a decoupling fetch queue.
//
// Pipelined, in-order fetches go out on a request/grant/response instruction bus.
// Each granted fetch takes a queue slot before its data returns. Returned
// instructions reach idu through a valid/ready handshake. A flush or jump
// redirect frees every slot. Responses still in flight for the old stream are
// counted in drop_cnt and discarded when they arrive.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush_i/_addr_i   pipe_ctrl redirect and target (wins over jump)
//   jump_flag_i/_addr_i idu redirect and target
//   inst_valid_o      head slot holds a returned instruction
//   inst_o            head instruction
//   inst_addr_o       head instruction address
//   inst_ready_i      idu accepts the head this cycle
//   ibus_req_o        fetch request
//   ibus_addr_o       fetch address
//   ibus_gnt_i        request accepted this cycle
//   ibus_rvalid_i     response valid; responses return in grant order
//   ibus_rdata_i      response data
//   stallreq_o        no instruction available for idu

module ifu_fetchq #(
   parameter int unsigned          ADDR_W     = 32,
   parameter int unsigned          INST_W     = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC   = 32'h8000_0000,
   parameter int unsigned          DEPTH      = 4,
   parameter int unsigned          INST_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_addr_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_ready_i,
   output logic              ibus_req_o,
   output logic [ADDR_W-1:0] ibus_addr_o,
   input  logic              ibus_gnt_i,
   input  logic              ibus_rvalid_i,
   input  logic [INST_W-1:0] ibus_rdata_i,
   output logic              stallreq_o
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   // One extra bit so that full and empty can be told apart.
   localparam int unsigned PtrW = IdxW + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              started_q;
   logic [PtrW-1:0]   alloc_ptr_q, alloc_ptr_d;
   logic [PtrW-1:0]   fill_ptr_q, fill_ptr_d;
   logic [PtrW-1:0]   head_ptr_q, head_ptr_d;
   logic [PtrW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [DEPTH-1:0]  filled_q, filled_d;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [INST_W-1:0] data_q [DEPTH];

   logic [PtrW-1:0]   count;
   logic [PtrW-1:0]   outstanding;
   logic [IdxW-1:0]   alloc_idx;
   logic [IdxW-1:0]   fill_idx;
   logic [IdxW-1:0]   head_idx;
   logic              redirect;
   logic              grant;
   logic              rsp_keep;
   logic              pop;

   assign alloc_idx   = alloc_ptr_q[IdxW-1:0];
   assign fill_idx    = fill_ptr_q[IdxW-1:0];
   assign head_idx    = head_ptr_q[IdxW-1:0];

   // Slots taken (waiting or filled, not yet popped) and fetches still on the bus.
   assign count       = alloc_ptr_q - head_ptr_q;
   assign outstanding = alloc_ptr_q - fill_ptr_q;

   assign redirect    = flush_i | jump_flag_i;

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      ibus_req_o   = started_q & ~redirect & (count < PtrW'(DEPTH));
      ibus_addr_o  = pc_q;
      inst_valid_o = (count != '0) & filled_q[head_idx];
      inst_o       = data_q[head_idx];
      inst_addr_o  = addr_q[head_idx];
      stallreq_o   = ~inst_valid_o;
   end

   assign grant    = ibus_req_o & ibus_gnt_i;
   assign rsp_keep = ibus_rvalid_i & (drop_cnt_q == '0);
   // A redirect wipes the queue, so a handshake in that cycle must not count.
   assign pop      = inst_valid_o & inst_ready_i & ~redirect;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d        = pc_q;
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      drop_cnt_d  = drop_cnt_q;
      filled_d    = filled_q;

      if (redirect) begin
         pc_d        = flush_i ? flush_addr_i : jump_addr_i;
         alloc_ptr_d = '0;
         fill_ptr_d  = '0;
         head_ptr_d  = '0;
         filled_d    = '0;
         // Every fetch still on the bus now belongs to the dead stream. A
         // response arriving this cycle takes one off: either it is one of the
         // outstanding fetches being thrown away, or it uses up an earlier drop.
         drop_cnt_d  = drop_cnt_q + outstanding - PtrW'(ibus_rvalid_i);
      end else begin
         if (grant) begin
            alloc_ptr_d         = alloc_ptr_q + PtrW'(1);
            pc_d                = pc_q + ADDR_W'(INST_BYTES);
            filled_d[alloc_idx] = 1'b0;
         end

         if (ibus_rvalid_i) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - PtrW'(1);
            end else begin
               fill_ptr_d         = fill_ptr_q + PtrW'(1);
               filled_d[fill_idx] = 1'b1;
            end
         end

         // The head slot can never also be the grant or fill target in a popping
         // cycle, so clearing it here cannot clash with the updates above.
         if (pop) begin
            head_ptr_d         = head_ptr_q + PtrW'(1);
            filled_d[head_idx] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         started_q   <= 1'b0;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         drop_cnt_q  <= '0;
         filled_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         started_q   <= 1'b1;
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         drop_cnt_q  <= drop_cnt_d;
         filled_q    <= filled_d;
      end
   end

   // Payload storage needs no reset: the filled flags and pointers decide
   // what is valid.
   always_ff @(posedge clk) begin
      if (grant) begin
         addr_q[alloc_idx] <= pc_q;
      end
      if (rsp_keep && !redirect) begin
         data_q[fill_idx] <= ibus_rdata_i;
      end
   end

endmodule

// File: tb/tb_ifu_fetchq.sv
// Directed testbench for ifu_fetchq with a small in-order bus responder.
// Each step drives inputs #1 after a rising edge and samples outputs before
// the next edge. Response data for address A is {A[15:0], 16'hC0DE}.

module tb_ifu_fetchq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] flush_addr_i = '0;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_ready_i = 1'b1;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i = 1'b1;
   logic        ibus_rvalid_i = 1'b0;
   logic [31:0] ibus_rdata_i = '0;
   logic        stallreq_o;

   ifu_fetchq dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .flush_addr_i (flush_addr_i),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o),
      .inst_ready_i (inst_ready_i),
      .ibus_req_o   (ibus_req_o),
      .ibus_addr_o  (ibus_addr_o),
      .ibus_gnt_i   (ibus_gnt_i),
      .ibus_rvalid_i(ibus_rvalid_i),
      .ibus_rdata_i (ibus_rdata_i),
      .stallreq_o   (stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   pend_t       pend[$];
   int unsigned cyc = 0;
   int unsigned lat = 1;
   int unsigned grants = 0;
   bit          rand_gnt = 1'b0;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], 16'hC0DE};
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: note what the edge will consume, cross it, then update the bus
   // responder (in-order, per-grant latency 'lat' >= 1).
   task automatic tick();
      logic        g;
      logic        rv;
      logic [31:0] a;
      #1;
      g  = ibus_req_o & ibus_gnt_i;
      a  = ibus_addr_o;
      rv = ibus_rvalid_i;
      @(posedge clk);
      #1;
      cyc++;
      if (rv && pend.size() > 0) void'(pend.pop_front());
      if (g) begin
         pend_t       p;
         int unsigned due;
         due = cyc + lat - 1;
         if (pend.size() > 0 && pend[$].due > due) due = pend[$].due;
         p.addr = a;
         p.due  = due;
         pend.push_back(p);
         grants++;
      end
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = data_of(pend[0].addr);
      end
      ibus_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20 && !inst_valid_o; i++) tick();
      chk1(tag, inst_valid_o, 1'b1);
   endtask

   task automatic enter_reset();
      rst = 1'b1;
      #1;
      pend.delete();
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = '0;
      flush_i       = 1'b0;
      jump_flag_i   = 1'b0;
      grants        = 0;
   endtask

   task automatic leave_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Redirect in the current cycle, then expect the first delivered address.
   task automatic redirect(input string tag, input logic f, input logic j,
                           input logic [31:0] fa, input logic [31:0] ja,
                           input logic [31:0] exp);
      flush_i      = f;
      jump_flag_i  = j;
      flush_addr_i = fa;
      jump_addr_i  = ja;
      #1;
      chk1({tag, "_req"}, ibus_req_o, 1'b0);
      tick();
      flush_i     = 1'b0;
      jump_flag_i = 1'b0;
      chk1({tag, "_valid"}, inst_valid_o, 1'b0);
      wait_valid({tag, "_timeout"});
      chk32({tag, "_addr"}, inst_addr_o, exp);
      chk32({tag, "_data"}, inst_o, data_of(exp));
   endtask

   initial begin
      logic [31:0] exp;
      int          pops;

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_req", ibus_req_o, 1'b0);
      chk1("rst_valid", inst_valid_o, 1'b0);
      chk1("rst_stall", stallreq_o, 1'b1);
      chk32("rst_addr", ibus_addr_o, 32'h8000_0000);

      // ---- startup and streaming, latency 1, ready=1 ----
      rst = 1'b0;
      tick();
      chk1("start_req", ibus_req_o, 1'b1);
      chk1("start_valid", inst_valid_o, 1'b0);
      chk32("start_addr", ibus_addr_o, 32'h8000_0000);
      tick();
      chk1("start_valid2", inst_valid_o, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         exp = 32'h8000_0000 + 32'(4 * k);
         chk1("seq_valid", inst_valid_o, 1'b1);
         chk1("seq_stall", stallreq_o, 1'b0);
         chk32("seq_addr", inst_addr_o, exp);
         chk32("seq_data", inst_o, data_of(exp));
         tick();
      end

      // ---- full back-pressure ----
      enter_reset();
      inst_ready_i = 1'b0;
      leave_reset();
      repeat (8) tick();
      chk32("bp_grants", 32'(grants), 32'd4);
      chk1("bp_req", ibus_req_o, 1'b0);
      chk1("bp_valid", inst_valid_o, 1'b1);
      chk32("bp_head", inst_addr_o, 32'h8000_0000);
      chk32("bp_pc", ibus_addr_o, 32'h8000_0010);
      inst_ready_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk32("bp_drain", inst_addr_o, 32'h8000_0000 + 32'(4 * k));
         if (k == 1) begin
            chk1("bp_resume", ibus_req_o, 1'b1);
            chk32("bp_resume_addr", ibus_addr_o, 32'h8000_0010);
         end
      end

      // ---- flush with two fetches in flight (latency 3) ----
      enter_reset();
      lat = 3;
      leave_reset();
      repeat (3) tick();
      chk32("fl_inflight", 32'(grants), 32'd2);
      chk1("fl_no_rsp", ibus_rvalid_i, 1'b0);
      flush_i      = 1'b1;
      flush_addr_i = 32'h8000_1000;
      #1;
      chk1("fl_req", ibus_req_o, 1'b0);
      tick();
      flush_i = 1'b0;
      chk32("fl_drop2", 32'(dut.drop_cnt_q), 32'd2);
      chk1("fl_valid", inst_valid_o, 1'b0);
      chk32("fl_pc", ibus_addr_o, 32'h8000_1000);
      tick();
      tick();
      chk32("fl_drop0", 32'(dut.drop_cnt_q), 32'd0);
      wait_valid("fl_timeout");
      chk32("fl_first", inst_addr_o, 32'h8000_1000);
      chk32("fl_data", inst_o, 32'h1000_C0DE);

      // ---- flush coincident with a response and a pop (latency 1) ----
      enter_reset();
      lat = 1;
      leave_reset();
      repeat (3) tick();
      chk1("co_valid_pre", inst_valid_o, 1'b1);
      chk1("co_rsp_pre", ibus_rvalid_i, 1'b1);
      flush_i      = 1'b1;
      flush_addr_i = 32'h8000_2000;
      tick();
      flush_i = 1'b0;
      chk32("co_drop", 32'(dut.drop_cnt_q), 32'd0);
      chk1("co_valid", inst_valid_o, 1'b0);
      wait_valid("co_timeout");
      chk32("co_first", inst_addr_o, 32'h8000_2000);

      // ---- jump redirect, then flush beating a simultaneous jump ----
      redirect("jmp", 1'b0, 1'b1, 32'h0, 32'h8000_3000, 32'h8000_3000);
      redirect("prio", 1'b1, 1'b1, 32'h8000_4000, 32'h8000_5000, 32'h8000_4000);

      // ---- random grant, latency 1..5, random ready ----
      enter_reset();
      rand_gnt = 1'b1;
      leave_reset();
      exp  = 32'h8000_0000;
      pops = 0;
      for (int c = 0; c < 300; c++) begin
         inst_ready_i = 1'($urandom_range(0, 1));
         lat          = $urandom_range(1, 5);
         if (inst_valid_o && inst_ready_i) begin
            chk32("rnd_addr", inst_addr_o, exp);
            chk32("rnd_data", inst_o, data_of(exp));
            exp = exp + 32'd4;
            pops++;
         end
         tick();
      end
      chk1("rnd_progress", pops > 20, 1'b1);
      rand_gnt = 1'b0;

      // ---- reset with a full queue ----
      inst_ready_i = 1'b0;
      repeat (12) tick();
      chk1("full_valid", inst_valid_o, 1'b1);
      chk1("full_req", ibus_req_o, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk1("mid_rst_req", ibus_req_o, 1'b0);
      chk1("mid_rst_valid", inst_valid_o, 1'b0);
      chk1("mid_rst_stall", stallreq_o, 1'b1);
      chk32("mid_rst_addr", ibus_addr_o, 32'h8000_0000);
      enter_reset();
      inst_ready_i = 1'b1;
      lat          = 1;
      leave_reset();
      repeat (3) tick();
      chk1("restart_valid", inst_valid_o, 1'b1);
      chk32("restart_addr", inst_addr_o, 32'h8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
